// File: rtl/seq_mult4_pkg.sv
// Shared constants for the sequential and array multipliers: state encodings,
// default operand width and counter sizing.
package seq_mult4_pkg;

    localparam int W_DEFAULT = 4;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef logic [1:0] state_t;

    // Iteration counter width: enough to hold W-1, plus one spare bit.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/seq_mult4_add_row.sv
// W-bit ripple adder row: a half adder in bit 0, full adders above it,
// with the final carry brought out.
module seq_mult4_add_row #(
    parameter int W = 4
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:1] carry;

    assign sum[0]   = x[0] ^ y[0];
    assign carry[1] = x[0] & y[0];

    for (genvar i = 1; i < W; i++) begin : g_fa
        assign sum[i]     = x[i] ^ y[i] ^ carry[i];
        assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
    end

    assign cout = carry[W];

endmodule

// File: rtl/seq_mult4.sv
// Sequential shift-add multiplier: unsigned W x W -> 2W product in W RUN cycles,
// with valid/ready handshakes on both the operand and product sides.
module seq_mult4
    import seq_mult4_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic [1:0]     dbg_state
);

    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_t         state;
    logic [W-1:0]   mcand;
    logic [W-1:0]   acc_hi;
    logic [W-1:0]   mplr;
    logic [CW-1:0]  cnt;

    logic [W-1:0]   addend;
    logic [W-1:0]   sum;
    logic           carry;
    logic [2*W-1:0] shifted;

    assign addend = mplr[0] ? mcand : '0;

    seq_mult4_add_row #(.W(W)) u_add_row (
        .x    (acc_hi),
        .y    (addend),
        .sum  (sum),
        .cout (carry)
    );

    // The carry-out becomes the new MSB, so no bit of the partial sum is lost.
    assign shifted = {carry, sum, mplr[W-1:1]};

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready/valid here depend only on state, never on the inputs.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mcand   <= '0;
            acc_hi  <= '0;
            mplr    <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= a;
                        mplr   <= b;
                        acc_hi <= '0;
                        cnt    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    {acc_hi, mplr} <= shifted;
                    cnt            <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        product <= shifted;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
